rotor_shift_pipeline: RTL and testbench
=======================================

# rotor_shift_pipeline

Parametrised, pipelined multi-rotor letter shifter for the Enigma datapath. Each accepted character passes through N_ROTORS modular shift stages, each adding (encrypt) or subtracting (decrypt) one rotor position modulo ALPHA_N. Rotor positions step like an odometer after every accepted character. A valid/ready stream interface sits between the character source and the display/output logic.

## Interface
- CHAR_W, 8: character and rotor-position width; letters are encoded 0..ALPHA_N-1.
- ALPHA_N, 26: alphabet size and modulus; must satisfy 2 <= ALPHA_N <= 2^(CHAR_W-1).
- N_ROTORS, 3: number of rotors, which is also the number of pipeline stages; must be >= 1.
- clk, input, 1: the single clock.
- resetn, input, 1: synchronous, active-low reset.
- in_valid, input, 1: in_char is valid.
- in_ready, output, 1: the block accepts in_char this cycle.
- in_char, input, CHAR_W: plaintext or ciphertext letter.
- decrypt, input, 1: 0 = add positions; 1 = subtract. Sampled with in_char.
- load, input, 1: load rotor positions this cycle.
- load_pos, input, N_ROTORS*CHAR_W: new positions; rotor 0 occupies the LSBs.
- out_valid, output, 1: out_char is valid.
- out_ready, input, 1: the sink takes out_char.
- out_char, output, CHAR_W: shifted letter.
- out_err, output, 1: the character was out of range and passed through unshifted.
- rotor_pos, output, N_ROTORS*CHAR_W: current rotor positions; rotor 0 occupies the LSBs.

## Operation
- Accept occurs when in_valid & in_ready. in_ready = ~load & (stage 0 empty | stage 0 advancing).
- On accept, the current rotor_pos vector and decrypt are captured and travel with the character. In-flight characters are never affected by later steps or loads.
- Stage k computes c' = (c ± pos[k]) mod ALPHA_N in CHAR_W+1 bits:
  - add: if sum >= ALPHA_N, subtract ALPHA_N;
  - sub: if the difference is negative, add ALPHA_N.
  - One correction step suffices because both operands are < ALPHA_N.
- Out-of-range input (in_char >= ALPHA_N): the character passes through all stages unchanged, out_err = 1, and the rotors do NOT step.
- Stepping on an in-range accept:
  - rotor 0 increments.
  - rotor k increments iff every rotor j<k was ALPHA_N-1 before the step.
  - Every rotor at ALPHA_N-1 that increments wraps to 0. Rotor N_ROTORS-1 wraps silently.
- load: rotor_pos takes load_pos next cycle. Any field >= ALPHA_N loads as 0. Load has priority over accept; in_ready is 0 during a load cycle.
- Each pipeline stage holds a valid bit, char, err, captured positions and mode. A stage advances when the next stage is empty or advancing. The final stage advances on out_ready.

## Timing
- While resetn=0 (sampled at clk edge): all stage valid bits = 0, out_valid = 0, out_char = 0, out_err = 0, rotor_pos = 0, in_ready = 0.
- Reset mid-operation discards in-flight characters without emitting them.
- Latency is N_ROTORS cycles from the accept edge to out_valid with no backpressure. Throughput is 1 character/cycle.
- While out_valid & ~out_ready, out_char and out_err are held stable.
- The pipeline holds at most N_ROTORS characters. Once it is full and stalled, in_ready = 0.
- rotor_pos updates on the edge after an accept or a load.
- If accept and out_ready occur in the same cycle on a full pipeline, the pipeline shifts and accepts; there is no bubble.

## Structure
- Shared package enigma_pkg holds:
  - ALPHA_N default 26 and CHAR_W default 8;
  - the helper function for the per-field out-of-range check.
- One sub-module, mod_shift_stage, implements a single registered modular add/sub stage with handshake, parametrised by CHAR_W and ALPHA_N. It is instantiated N_ROTORS times via generate.
- Odometer stepping and the load logic live in the top level.

## Test plan
Defaults are used throughout (26/8/3).
- Reset, then load {0,0,0} and encrypt chars 0,0,0 back-to-back -> out_char 0,1,2 on consecutive cycles, first output 3 cycles after the first accept; rotor_pos ends at {0,0,3}.
- Odometer: load r0=25, r1=25, r2=0, encrypt 3 -> out 1 (53 mod 26). rotor_pos becomes r0=0, r1=0, r2=1. Next char 3 -> out 4.
- Round trip: encrypt 0..25 from load {5,12,20}, reload {5,12,20}, decrypt the ciphertext -> 0..25 recovered exactly, all out_err = 0.
- Backpressure: hold out_ready=0 for 6 cycles while driving 5 chars -> exactly 3 accepted, then in_ready = 0. out_char stays stable. After release, all chars arrive in order with no loss or duplication.
- Out-of-range: in_char 30 -> out_char 30 with out_err = 1 and rotor_pos unchanged. Load with r1=40 -> r1 = 0. Load and in_valid in the same cycle -> no accept that cycle.
- Reset mid-stream: resetn=0 for 1 cycle with 2 characters in flight -> out_valid stays 0 afterwards with no stale outputs, rotor_pos = 0.

Source files
------------

// File: rtl/enigma_pkg.sv
// Shared Enigma datapath definitions: default geometry, shift direction and
// the per-field range check used on characters and rotor loads.
package enigma_pkg;

   localparam int unsigned ALPHA_N_DEF = 26;
   localparam int unsigned CHAR_W_DEF  = 8;

   typedef enum logic {
      SHIFT_ADD = 1'b0,
      SHIFT_SUB = 1'b1
   } shift_mode_e;

   function automatic logic out_of_range(input int unsigned value, input int unsigned alpha_n);
      return value >= alpha_n;
   endfunction

endpackage

// File: rtl/rotor_shift_pipeline_if.sv
// Character stream, rotor load and rotor status bundle for rotor_shift_pipeline.
interface rotor_shift_pipeline_if import enigma_pkg::*; #(
   parameter int unsigned CHAR_W   = CHAR_W_DEF,
   parameter int unsigned N_ROTORS = 3
);

   logic                         in_valid;
   logic                         in_ready;
   logic [CHAR_W-1:0]            in_char;
   logic                         decrypt;
   logic                         load;
   logic [N_ROTORS*CHAR_W-1:0]   load_pos;
   logic                         out_valid;
   logic                         out_ready;
   logic [CHAR_W-1:0]            out_char;
   logic                         out_err;
   logic [N_ROTORS*CHAR_W-1:0]   rotor_pos;

   modport master (
      output in_valid, in_char, decrypt, load, load_pos, out_ready,
      input  in_ready, out_valid, out_char, out_err, rotor_pos
   );

   modport slave (
      input  in_valid, in_char, decrypt, load, load_pos, out_ready,
      output in_ready, out_valid, out_char, out_err, rotor_pos
   );

endinterface

// File: rtl/mod_shift_stage.sv
// One registered modular add/sub stage; shifts by rotor STAGE_IDX of the
// position vector that travels with the character.
module mod_shift_stage import enigma_pkg::*; #(
   parameter int unsigned CHAR_W    = CHAR_W_DEF,
   parameter int unsigned ALPHA_N   = ALPHA_N_DEF,
   parameter int unsigned N_ROTORS  = 3,
   parameter int unsigned STAGE_IDX = 0
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       up_valid,
   output logic                       up_ready,
   input  logic [CHAR_W-1:0]          up_char,
   input  logic                       up_err,
   input  logic [N_ROTORS*CHAR_W-1:0] up_pos,
   input  shift_mode_e                up_mode,
   output logic                       dn_valid,
   input  logic                       dn_ready,
   output logic [CHAR_W-1:0]          dn_char,
   output logic                       dn_err,
   output logic [N_ROTORS*CHAR_W-1:0] dn_pos,
   output shift_mode_e                dn_mode
);

   localparam logic [CHAR_W:0] MODULUS = (CHAR_W+1)'(ALPHA_N);

   logic [CHAR_W-1:0] pos_k;
   logic [CHAR_W:0]   wide;
   logic [CHAR_W-1:0] result;

   assign pos_k    = up_pos[STAGE_IDX*CHAR_W +: CHAR_W];
   assign up_ready = ~dn_valid | dn_ready;

   // Both operands are below ALPHA_N, so a single correction lands in range.
   always_comb begin
      wide   = '0;
      result = up_char;
      if (up_mode == SHIFT_ADD) begin
         wide = {1'b0, up_char} + {1'b0, pos_k};
         if (wide >= MODULUS) wide = wide - MODULUS;
      end else begin
         wide = {1'b0, up_char} - {1'b0, pos_k};
         if (wide[CHAR_W]) wide = wide + MODULUS;
      end
      if (!up_err) result = wide[CHAR_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         dn_valid <= 1'b0;
         dn_char  <= '0;
         dn_err   <= 1'b0;
         dn_pos   <= '0;
         dn_mode  <= SHIFT_ADD;
      end else if (up_ready) begin
         dn_valid <= up_valid;
         if (up_valid) begin
            dn_char <= result;
            dn_err  <= up_err;
            dn_pos  <= up_pos;
            dn_mode <= up_mode;
         end
      end
   end

endmodule

// File: rtl/rotor_shift_pipeline.sv
// Pipelined multi-rotor letter shifter: one mod_shift_stage per rotor, with
// odometer rotor stepping and rotor loading handled here.
module rotor_shift_pipeline import enigma_pkg::*; #(
   parameter int unsigned CHAR_W   = CHAR_W_DEF,
   parameter int unsigned ALPHA_N  = ALPHA_N_DEF,
   parameter int unsigned N_ROTORS = 3
) (
   input  logic clk,
   input  logic resetn,
   rotor_shift_pipeline_if.slave bus
);

   localparam int unsigned       POS_W   = N_ROTORS * CHAR_W;
   localparam logic [CHAR_W-1:0] POS_MAX = CHAR_W'(ALPHA_N - 1);

   logic [POS_W-1:0]  rotor_q;
   logic [POS_W-1:0]  rotor_step;
   logic [POS_W-1:0]  rotor_load;
   logic [CHAR_W-1:0] field;
   logic              carry;
   logic              accept;
   logic              in_err;
   logic              unused_tail;

   assign in_err        = out_of_range(32'(bus.in_char), ALPHA_N);
   assign bus.in_ready  = resetn & ~bus.load & g_stage[0].s_up_ready;
   assign accept        = bus.in_valid & bus.in_ready;
   assign bus.rotor_pos = rotor_q;

   for (genvar k = 0; k < N_ROTORS; k++) begin : g_stage
      logic              s_up_valid, s_up_ready, s_up_err;
      logic              s_dn_valid, s_dn_ready, s_dn_err;
      logic [CHAR_W-1:0] s_up_char, s_dn_char;
      logic [POS_W-1:0]  s_up_pos, s_dn_pos;
      shift_mode_e       s_up_mode, s_dn_mode;

      if (k == 0) begin : g_head
         assign s_up_valid = accept;
         assign s_up_char  = bus.in_char;
         assign s_up_err   = in_err;
         assign s_up_pos   = rotor_q;
         assign s_up_mode  = shift_mode_e'(bus.decrypt);
      end else begin : g_link
         assign s_up_valid = g_stage[k-1].s_dn_valid;
         assign s_up_char  = g_stage[k-1].s_dn_char;
         assign s_up_err   = g_stage[k-1].s_dn_err;
         assign s_up_pos   = g_stage[k-1].s_dn_pos;
         assign s_up_mode  = g_stage[k-1].s_dn_mode;
      end

      if (k == N_ROTORS - 1) begin : g_tail
         assign s_dn_ready = bus.out_ready;
      end else begin : g_mid
         assign s_dn_ready = g_stage[k+1].s_up_ready;
      end

      mod_shift_stage #(
         .CHAR_W    (CHAR_W),
         .ALPHA_N   (ALPHA_N),
         .N_ROTORS  (N_ROTORS),
         .STAGE_IDX (k)
      ) u_stage (
         .clk      (clk),
         .resetn   (resetn),
         .up_valid (s_up_valid),
         .up_ready (s_up_ready),
         .up_char  (s_up_char),
         .up_err   (s_up_err),
         .up_pos   (s_up_pos),
         .up_mode  (s_up_mode),
         .dn_valid (s_dn_valid),
         .dn_ready (s_dn_ready),
         .dn_char  (s_dn_char),
         .dn_err   (s_dn_err),
         .dn_pos   (s_dn_pos),
         .dn_mode  (s_dn_mode)
      );
   end

   assign bus.out_valid = g_stage[N_ROTORS-1].s_dn_valid;
   assign bus.out_char  = g_stage[N_ROTORS-1].s_dn_char;
   assign bus.out_err   = g_stage[N_ROTORS-1].s_dn_err;
   assign unused_tail   = ^{g_stage[N_ROTORS-1].s_dn_pos, g_stage[N_ROTORS-1].s_dn_mode};

   // Carry ripples upward only while every lower rotor sits at its last letter.
   always_comb begin
      rotor_step = rotor_q;
      rotor_load = '0;
      field      = '0;
      carry      = 1'b1;
      for (int unsigned k = 0; k < N_ROTORS; k++) begin
         field = rotor_q[k*CHAR_W +: CHAR_W];
         if (carry) rotor_step[k*CHAR_W +: CHAR_W] = (field == POS_MAX) ? '0 : field + CHAR_W'(1);
         carry = carry & (field == POS_MAX);
         if (!out_of_range(32'(bus.load_pos[k*CHAR_W +: CHAR_W]), ALPHA_N))
            rotor_load[k*CHAR_W +: CHAR_W] = bus.load_pos[k*CHAR_W +: CHAR_W];
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         rotor_q <= '0;
      end else if (bus.load) begin
         rotor_q <= rotor_load;
      end else if (accept && !in_err) begin
         rotor_q <= rotor_step;
      end
   end

endmodule

// File: tb/tb_rotor_shift_pipeline.sv
// Randomised and directed bench for rotor_shift_pipeline against a
// queue-based model using whole-alphabet arithmetic and an odometer counter.
module tb_rotor_shift_pipeline;

   localparam int CW = 8;
   localparam int AN = 26;
   localparam int NR = 3;
   localparam int PW = NR * CW;

   typedef struct {
      int ch;
      bit err;
      int t;
   } exp_t;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   rotor_shift_pipeline_if #(.CHAR_W(CW), .N_ROTORS(NR)) bus ();

   rotor_shift_pipeline #(.CHAR_W(CW), .ALPHA_N(AN), .N_ROTORS(NR)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   exp_t q[$];
   int   got[$];
   int   ct[$];
   int   rot[NR];
   int   cyc = 0;
   bit   rst_prev = 1'b0;
   bit   last_acc = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;

   task automatic check_eq(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
      n_tests++;
      if (got_v !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got_v, exp_v);
      end
   endtask

   function automatic logic [PW-1:0] pack_rot();
      logic [PW-1:0] v;
      v = '0;
      for (int k = 0; k < NR; k++) v[k*CW +: CW] = CW'(rot[k]);
      return v;
   endfunction

   task automatic odometer_step();
      int v, m;
      v = 0;
      m = 1;
      for (int k = NR - 1; k >= 0; k--) begin
         v = v * AN + rot[k];
         m = m * AN;
      end
      v = (v + 1) % m;
      for (int k = 0; k < NR; k++) begin
         rot[k] = v % AN;
         v = v / AN;
      end
   endtask

   task automatic cycle();
      int   cnt, s, c;
      bit   exp_ir, exp_ov, acc_m, pop_m;
      exp_t e;
      logic [PW-1:0] lp;
      @(negedge clk);
      cnt    = q.size();
      exp_ir = resetn && !bus.load && (cnt < NR || bus.out_ready);
      exp_ov = (cnt > 0) && (cyc - q[0].t >= NR - 1);
      check_eq("in_ready", bus.in_ready, exp_ir);
      check_eq("out_valid", bus.out_valid, exp_ov);
      if (exp_ov) begin
         check_eq("out_char", bus.out_char, q[0].ch);
         check_eq("out_err", bus.out_err, q[0].err);
      end
      check_eq("rotor_pos", bus.rotor_pos, pack_rot());
      if (rst_prev) begin
         check_eq("rst_out_char", bus.out_char, 0);
         check_eq("rst_out_err", bus.out_err, 0);
      end
      last_acc = bus.in_valid && bus.in_ready;
      if (bus.out_valid && bus.out_ready) got.push_back(int'(bus.out_char));
      acc_m = exp_ir && bus.in_valid;
      pop_m = exp_ov && bus.out_ready;
      c  = int'(bus.in_char);
      lp = bus.load_pos;
      @(posedge clk);
      cyc++;
      rst_prev = !resetn;
      if (!resetn) begin
         q.delete();
         for (int k = 0; k < NR; k++) rot[k] = 0;
      end else begin
         if (pop_m) void'(q.pop_front());
         if (bus.load) begin
            for (int k = 0; k < NR; k++) begin
               rot[k] = int'(lp[k*CW +: CW]);
               if (rot[k] >= AN) rot[k] = 0;
            end
         end else if (acc_m) begin
            s = 0;
            for (int k = 0; k < NR; k++) s += rot[k];
            e.t = cyc;
            if (c >= AN) begin
               e.ch  = c;
               e.err = 1'b1;
            end else begin
               e.err = 1'b0;
               e.ch  = bus.decrypt ? (((c - s) % AN) + AN) % AN : (c + s) % AN;
               odometer_step();
            end
            q.push_back(e);
         end
      end
      #1;
   endtask

   task automatic load_rotors(input logic [PW-1:0] p);
      bus.in_valid = 1'b0;
      bus.load     = 1'b1;
      bus.load_pos = p;
      cycle();
      bus.load = 1'b0;
   endtask

   task automatic send(input int c, input bit dec);
      bit ok;
      ok = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_char  = CW'(c);
      bus.decrypt  = dec;
      for (int i = 0; i < 20 && !ok; i++) begin
         cycle();
         ok = last_acc;
      end
      if (!ok) check_eq("send_timeout", 0, 1);
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      bus.in_valid  = 1'b0;
      bus.load      = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 40 && q.size() > 0; i++) cycle();
      cycle();
   endtask

   initial begin
      int bp[5];
      int idx, acc;
      bp = '{10, 11, 12, 13, 14};
      bus.in_valid  = 1'b0;
      bus.in_char   = '0;
      bus.decrypt   = 1'b0;
      bus.load      = 1'b0;
      bus.load_pos  = '0;
      bus.out_ready = 1'b1;
      for (int k = 0; k < NR; k++) rot[k] = 0;

      // reset
      @(posedge clk);
      #1;
      rst_prev = 1'b1;
      cycle();
      cycle();
      resetn = 1'b1;

      // back-to-back encrypt from zero rotors
      load_rotors('0);
      got.delete();
      for (int i = 0; i < 3; i++) send(0, 1'b0);
      check_eq("t1_rotor", bus.rotor_pos, 24'h000003);
      drain();
      check_eq("t1_count", got.size(), 3);
      for (int i = 0; i < 3 && i < got.size(); i++) check_eq("t1_char", got[i], i);

      // odometer carry across two rotors
      load_rotors({8'd0, 8'd25, 8'd25});
      got.delete();
      send(3, 1'b0);
      check_eq("odo_rotor", bus.rotor_pos, 24'h010000);
      send(3, 1'b0);
      drain();
      check_eq("odo_count", got.size(), 2);
      if (got.size() == 2) begin
         check_eq("odo_char0", got[0], 1);
         check_eq("odo_char1", got[1], 4);
      end

      // round trip
      load_rotors({8'd20, 8'd12, 8'd5});
      got.delete();
      for (int i = 0; i < AN; i++) send(i, 1'b0);
      drain();
      ct = got;
      load_rotors({8'd20, 8'd12, 8'd5});
      got.delete();
      for (int i = 0; i < ct.size(); i++) send(ct[i], 1'b1);
      drain();
      check_eq("rt_count", got.size(), AN);
      for (int i = 0; i < AN && i < got.size(); i++) check_eq("rt_char", got[i], i);

      // backpressure
      load_rotors('0);
      got.delete();
      bus.out_ready = 1'b0;
      idx = 0;
      acc = 0;
      for (int n = 0; n < 6; n++) begin
         bus.in_valid = (idx < 5);
         bus.in_char  = CW'(bp[idx < 5 ? idx : 4]);
         bus.decrypt  = 1'b0;
         cycle();
         if (last_acc) begin
            idx++;
            acc++;
         end
      end
      check_eq("bp_accepted", acc, 3);
      check_eq("bp_in_ready", bus.in_ready, 0);
      bus.out_ready = 1'b1;
      for (int n = 0; n < 20 && idx < 5; n++) begin
         bus.in_valid = 1'b1;
         bus.in_char  = CW'(bp[idx]);
         cycle();
         if (last_acc) idx++;
      end
      drain();
      check_eq("bp_count", got.size(), 5);

      // out-of-range character, clamped load, load blocks accept
      got.delete();
      send(30, 1'b0);
      check_eq("oor_rotor", bus.rotor_pos, 24'h000005);
      drain();
      check_eq("oor_count", got.size(), 1);
      if (got.size() == 1) check_eq("oor_char", got[0], 30);
      load_rotors({8'd0, 8'd40, 8'd7});
      check_eq("clamp_rotor", bus.rotor_pos, 24'h000007);
      bus.load     = 1'b1;
      bus.load_pos = '0;
      bus.in_valid = 1'b1;
      bus.in_char  = CW'(1);
      cycle();
      check_eq("load_blocks_accept", last_acc, 0);
      bus.load     = 1'b0;
      bus.in_valid = 1'b0;

      // reset mid-stream
      send(4, 1'b0);
      send(5, 1'b0);
      got.delete();
      resetn = 1'b0;
      cycle();
      resetn = 1'b1;
      repeat (6) cycle();
      check_eq("mid_rst_outputs", got.size(), 0);
      check_eq("mid_rst_rotor", bus.rotor_pos, 0);

      // random traffic
      for (int n = 0; n < 400; n++) begin
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.in_char   = CW'($urandom_range(0, 29));
         bus.decrypt   = $urandom_range(0, 1) != 0;
         bus.load      = ($urandom_range(0, 19) == 0);
         for (int k = 0; k < NR; k++) bus.load_pos[k*CW +: CW] = CW'($urandom_range(0, 31));
         bus.out_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
